// File: rtl/bus_reg_bank_if.sv
// Request/status bundle for bus_reg_bank. The tri-state read bus stays a plain
// module port so it resolves like any other shared bus wire.
interface bus_reg_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 2
) ();
  logic             select;
  logic             wenable;
  logic             renable;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data;
  logic             rvalid;
  logic             aerr;

  modport master (
    output select, wenable, renable, addr, data,
    input  rvalid, aerr
  );

  modport slave (
    input  select, wenable, renable, addr, data,
    output rvalid, aerr
  );
endinterface

// File: rtl/bus_reg_bank.sv
// Parametrised register bank on a shared tri-state read bus.
// DEPTH words of WIDTH bits, synchronous writes, registered reads driven on o
// for HOLD cycles and then released to Z. Sticky aerr flags out-of-range use.
// Optional feature: define BUS_REG_BANK_CLR_EN to add a synchronous clear input
// that zeroes every word and aborts an in-progress read.
module bus_reg_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned HOLD  = 2
) (
  input  logic             clock,
  input  logic             reset,
  bus_reg_bank_if.slave    bus,
`ifdef BUS_REG_BANK_CLR_EN
  input  logic             clear,
`endif
  output wire  [WIDTH-1:0] o
);

  typedef enum logic {StIdle, StDrive} state_e;

  // DEPTH may equal 2**AW, so compare with one extra bit.
  localparam logic [AW:0] DepthW   = (AW+1)'(DEPTH);
  localparam logic [3:0]  HoldInit = 4'(HOLD - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             aerr_q;

  logic in_range;
  logic wr_ok;
  logic rd_ok;
  logic bad_req;
  logic clr;

`ifdef BUS_REG_BANK_CLR_EN
  assign clr = clear;
`else
  assign clr = 1'b0;
`endif

  assign in_range = ({1'b0, bus.addr} < DepthW);
  assign wr_ok    = bus.select & bus.wenable & in_range;
  assign rd_ok    = bus.select & bus.renable & in_range;
  assign bad_req  = bus.select & (bus.wenable | bus.renable) & ~in_range;

  // Word storage: reset/clear zero everything, otherwise accept in-range writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[bus.addr] <= bus.data;
    end
  end

  // Read FSM: capture on accept, hold for HOLD cycles, re-accept only on the last one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rd_ok) begin
            // mem_q still holds the old word on a same-cycle write.
            rdata_q <= mem_q[bus.addr];
            cnt_q   <= HoldInit;
            state_q <= StDrive;
          end
        end
        StDrive: begin
          if (cnt_q == 4'd0) begin
            if (rd_ok) begin
              rdata_q <= mem_q[bus.addr];
              cnt_q   <= HoldInit;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Sticky address error; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aerr_q <= 1'b0;
    end else if (bad_req) begin
      aerr_q <= 1'b1;
    end
  end

  assign bus.rvalid = (state_q == StDrive);
  assign bus.aerr   = aerr_q;
  assign o          = (state_q == StDrive) ? rdata_q : {WIDTH{1'bz}};

endmodule
